// File: rtl/cond_unit.sv
// cond_unit: ARM-style condition evaluation, NZCV flag register and annulled-instruction counter
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   StallE, FlushE             E-stage hold and bubble controls
//   CondE, FlagWriteE, ALUFlags condition field, per-half flag write enables, ALU {N,Z,C,V}
//   PCSrcE, RegWriteE, MemWriteE, BranchE  decoded side effects of the E instruction
//   ClrCntE                    synchronous clear of SkipCnt
//   CondExE                    condition passed against registered flags
//   PCSrcGE, RegWriteGE, MemWriteGE  condition- and flush-gated side effects
//   FlagsQ, SkipCnt            registered {N,Z,C,V} and saturating annul count
module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [3:0]       CondE,
  input  logic [1:0]       FlagWriteE,
  input  logic [3:0]       ALUFlags,
  input  logic             PCSrcE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             BranchE,
  input  logic             ClrCntE,
  output logic             CondExE,
  output logic             PCSrcGE,
  output logic             RegWriteGE,
  output logic             MemWriteGE,
  output logic [3:0]       FlagsQ,
  output logic [CNT_W-1:0] SkipCnt
);
  logic n, z, c, v, lt;
  logic [15:0] pass;
  logic go;
  assign {n, z, c, v} = FlagsQ;
  assign lt = n ^ v;
  // one result bit per condition code, indexed by CondE; code 1111 is reserved and never passes
  assign pass = {1'b0, 1'b1, z | lt, ~z & ~lt, lt, ~lt, ~c | z, c & ~z,
                 ~v, v, ~n, n, ~c, c, ~z, z};
  assign CondExE    = pass[CondE];
  assign go         = ~StallE & ~FlushE;
  assign PCSrcGE    = (PCSrcE | BranchE) & CondExE & ~FlushE;
  assign RegWriteGE = RegWriteE & CondExE & ~FlushE;
  assign MemWriteGE = MemWriteE & CondExE & ~FlushE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      FlagsQ  <= '0;
      SkipCnt <= '0;
    end else begin
      if (go & CondExE & FlagWriteE[1]) FlagsQ[3:2] <= ALUFlags[3:2];
      if (go & CondExE & FlagWriteE[0]) FlagsQ[1:0] <= ALUFlags[1:0];
      if (ClrCntE) SkipCnt <= '0;
      else if (go & ~CondExE & (SkipCnt != '1)) SkipCnt <= SkipCnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed scoreboard bench for cond_unit with a 4-bit annul counter
module tb_cond_unit;
  logic clk, reset, StallE, FlushE, PCSrcE, RegWriteE, MemWriteE, BranchE, ClrCntE;
  logic [3:0] CondE, ALUFlags, FlagsQ, SkipCnt;
  logic [1:0] FlagWriteE;
  logic CondExE, PCSrcGE, RegWriteGE, MemWriteGE;

  cond_unit #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .CondE(CondE),
    .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .ClrCntE(ClrCntE), .CondExE(CondExE),
    .PCSrcGE(PCSrcGE), .RegWriteGE(RegWriteGE), .MemWriteGE(MemWriteGE),
    .FlagsQ(FlagsQ), .SkipCnt(SkipCnt)
  );

  typedef struct {
    string      nm;
    logic [11:0] exp;
  } exp_t;
  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // expected vector layout: {CondExE, PCSrcGE, RegWriteGE, MemWriteGE, FlagsQ, SkipCnt}
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [11:0] act;
      e = q.pop_front();
      act = {CondExE, PCSrcGE, RegWriteGE, MemWriteGE, FlagsQ, SkipCnt};
      compared++;
      if (act !== e.exp) begin
        mismatched++;
        $display("FAIL %s: got %b required %b", e.nm, act, e.exp);
      end
    end
  end

  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] cc, input logic [1:0] fw, input logic [3:0] alu,
                       input logic [3:0] dec, input logic st, input logic fl, input logic clr);
    CondE = cc;
    FlagWriteE = fw;
    ALUFlags = alu;
    {PCSrcE, RegWriteE, MemWriteE, BranchE} = dec;
    StallE = st;
    FlushE = fl;
    ClrCntE = clr;
  endtask

  task automatic chk(input string nm, input logic [11:0] e);
    exp_t x;
    x.nm = nm;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int budget;
    reset = 1;
    drive(4'h0, 2'b00, 4'h0, 4'b0000, 0, 0, 0);
    tick();
    drive(4'h0, 2'b00, 4'h0, 4'b0100, 0, 0, 0);
    chk("reset_eq", 12'b0000_0000_0000);
    tick();
    drive(4'h1, 2'b00, 4'h0, 4'b0100, 0, 0, 0);
    chk("reset_ne", 12'b1010_0000_0000);
    tick();
    reset = 0;
    drive(4'hE, 2'b11, 4'b0100, 4'b0000, 0, 0, 0);
    chk("al_setflags", 12'b1000_0000_0000);
    tick();
    drive(4'h0, 2'b00, 4'h0, 4'b0001, 0, 0, 0);
    chk("beq_taken", 12'b1100_0100_0000);
    tick();
    drive(4'hE, 2'b01, 4'b1011, 4'b0000, 0, 0, 0);
    chk("cv_write", 12'b1000_0100_0000);
    tick();
    drive(4'hE, 2'b00, 4'h0, 4'b0000, 0, 0, 0);
    chk("cv_only", 12'b1000_0111_0000);
    tick();
    drive(4'hE, 2'b11, 4'b1000, 4'b0000, 0, 0, 0);
    tick();
    drive(4'hA, 2'b11, 4'b0110, 4'b0110, 0, 0, 0);
    chk("ge_fail", 12'b0000_1000_0000);
    tick();
    drive(4'hE, 2'b00, 4'h0, 4'b0000, 0, 0, 0);
    chk("ge_fail_after", 12'b1000_1000_0001);
    tick();
    drive(4'hA, 2'b11, 4'h0, 4'b0000, 1, 0, 0);
    chk("stall_fail", 12'b0000_1000_0001);
    tick();
    drive(4'hE, 2'b11, 4'h0, 4'b0100, 1, 0, 0);
    chk("stall_pass", 12'b1010_1000_0001);
    tick();
    drive(4'hE, 2'b00, 4'h0, 4'b0000, 0, 0, 0);
    chk("stall_hold", 12'b1000_1000_0001);
    tick();
    drive(4'hE, 2'b11, 4'h0, 4'b1111, 0, 1, 0);
    chk("flush_pass", 12'b1000_1000_0001);
    tick();
    drive(4'hA, 2'b11, 4'h0, 4'b1111, 0, 1, 0);
    chk("flush_fail", 12'b0000_1000_0001);
    tick();
    drive(4'hE, 2'b00, 4'h0, 4'b0000, 0, 0, 0);
    chk("flush_hold", 12'b1000_1000_0001);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(4'hF, 2'b11, 4'h0, 4'b0100, 0, 0, 0);
      if (i == 14) chk("sat_reach", 12'b0000_1000_1111);
      tick();
    end
    drive(4'hE, 2'b00, 4'h0, 4'b0000, 0, 0, 0);
    chk("sat_hold", 12'b1000_1000_1111);
    tick();
    drive(4'hF, 2'b00, 4'h0, 4'b0000, 0, 0, 1);
    chk("clr_fail", 12'b0000_1000_1111);
    tick();
    drive(4'hE, 2'b11, 4'b1111, 4'b0000, 0, 0, 0);
    chk("clr_after", 12'b1000_1000_0000);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'hF, 2'b00, 4'h0, 4'b0000, 0, 0, 0);
      tick();
    end
    drive(4'hE, 2'b00, 4'h0, 4'b0000, 1, 0, 0);
    chk("pre_reset", 12'b1000_1111_0011);
    tick();
    drive(4'hE, 2'b11, 4'b1111, 4'b0000, 1, 0, 0);
    #1 reset = 1;
    chk("async_reset", 12'b1000_0000_0000);
    tick();
    reset = 0;
    drive(4'hE, 2'b11, 4'b0010, 4'b0000, 0, 0, 0);
    tick();
    drive(4'h2, 2'b00, 4'h0, 4'b0000, 0, 0, 0);
    chk("resume", 12'b1000_0010_0000);
    tick();
    for (int f = 0; f < 16; f++) begin
      drive(4'hE, 2'b11, 4'(f), 4'b0000, 0, 0, 1);
      tick();
      for (int c = 0; c < 16; c++) begin
        logic ok;
        ok = cond_ok(4'(c), 4'(f));
        drive(4'(c), 2'b00, 4'h0, 4'b1110, 0, 0, 1);
        chk($sformatf("sweep_c%0d_f%0d", c, f), {ok, ok, ok, ok, 4'(f), 4'h0});
        tick();
      end
    end
    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      tick();
      budget++;
    end
    if (q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
